dequant_unpacker: RTL and testbench



---
 rtl/dequant_pkg.sv | 19 +
 rtl/dequant_lane.sv | 17 +
 rtl/dequant_unpacker.sv | 143 ++++++++++++++
 tb/tb_dequant_unpacker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dequant_pkg.sv
// Shared types and helpers for the packed-word dequantizer.
// Imported by dequant_lane and dequant_unpacker.
package dequant_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Lane-index width, never narrower than one bit so LANES=1 still has a port.
  function automatic int lane_w(input int lanes);
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

  function automatic int shift_amt(input int frac_out, input int frac_in);
    return frac_out - frac_in;
  endfunction

endpackage

// File: rtl/dequant_lane.sv
// Combinational narrow-to-wide fixed-point expander: sign-extend, then align
// the binary point by shifting left (the low fraction bits fill with zero).
module dequant_lane #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 4
) (
  input  logic [IN_WIDTH-1:0]  i_val,
  output logic [OUT_WIDTH-1:0] o_val
);

  logic signed [OUT_WIDTH-1:0] w_ext;

  assign w_ext = OUT_WIDTH'(signed'(i_val));
  assign o_val = w_ext << SHIFT;

endmodule

// File: rtl/dequant_unpacker.sv
// Streaming dequantizer: takes a packed word of LANES narrow values and emits
// them one per cycle as wide values. Optional out_count under DEQUANT_COUNT_EN.
module dequant_unpacker
  import dequant_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int FRAC_IN   = 4,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_OUT  = 8,
  parameter int LANES     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*IN_WIDTH-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [lane_w(LANES)-1:0]    out_lane,
  output logic                        out_last,
  output state_t                      dbg_state
`ifdef DEQUANT_COUNT_EN
  ,
  output logic [31:0]                 out_count
`endif
);

  localparam int LW    = lane_w(LANES);
  localparam int SHIFT = shift_amt(FRAC_OUT, FRAC_IN);

  if (FRAC_OUT < FRAC_IN) begin : g_chk_frac
    $fatal(1, "dequant_unpacker: FRAC_OUT must be >= FRAC_IN");
  end
  if ((OUT_WIDTH - FRAC_OUT) < (IN_WIDTH - FRAC_IN)) begin : g_chk_int
    $fatal(1, "dequant_unpacker: output integer part narrower than input");
  end
  if (FRAC_IN >= IN_WIDTH) begin : g_chk_in
    $fatal(1, "dequant_unpacker: FRAC_IN must be < IN_WIDTH");
  end
  if (LANES < 1) begin : g_chk_lanes
    $fatal(1, "dequant_unpacker: LANES must be >= 1");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and data stable until it transfers; ready may
  // depend combinationally on the other side (in_ready follows out_ready on
  // the last lane so words can go back to back).

  state_t                    r_state;
  state_t                    w_next_state;
  logic [LANES*IN_WIDTH-1:0] r_word;
  logic [LW-1:0]             r_lane;
  logic [OUT_WIDTH-1:0]      r_out_data;
  logic                      r_out_last;

  logic                      w_fire;
  logic                      w_in_ready;
  logic                      w_accept;
  logic [LW-1:0]             w_next_lane;
  logic [IN_WIDTH-1:0]       w_sel;
  logic [OUT_WIDTH-1:0]      w_exp;

  assign out_valid   = (r_state == EMIT);
  assign w_fire      = out_valid && out_ready;
  assign w_in_ready  = (r_state == IDLE) || (w_fire && r_out_last);
  assign w_accept    = in_valid && w_in_ready;
  assign w_next_lane = r_lane + LW'(1);

  // A newly accepted word feeds lane 0 straight from in_data.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_next_lane == LW'(i)) w_sel = r_word[i*IN_WIDTH +: IN_WIDTH];
    end
    if (w_accept) w_sel = in_data[IN_WIDTH-1:0];
  end

  dequant_lane #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_lane (
    .i_val(w_sel),
    .o_val(w_exp)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = EMIT;
      EMIT: if (w_fire && r_out_last) w_next_state = in_valid ? EMIT : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_lane     <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else if (w_accept) begin
      r_word     <= in_data;
      r_lane     <= '0;
      r_out_data <= w_exp;
      r_out_last <= (LANES == 1);
    end else if (w_fire && !r_out_last) begin
      r_lane     <= w_next_lane;
      r_out_data <= w_exp;
      r_out_last <= (w_next_lane == LW'(LANES - 1));
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_lane  = r_lane;
  assign out_last  = r_out_last;
  assign dbg_state = r_state;

`ifdef DEQUANT_COUNT_EN
  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_fire) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign out_count = r_count;
`endif

endmodule

// File: tb/tb_dequant_unpacker.sv
// Directed bench for dequant_unpacker (default parameters). Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_dequant_unpacker;
  import dequant_pkg::*;

  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 16;
  localparam int LANES     = 4;
  localparam int LW        = 2;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*IN_WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_WIDTH-1:0]      out_data;
  logic [LW-1:0]             out_lane;
  logic                      out_last;
  state_t                    dbg_state;
`ifdef DEQUANT_COUNT_EN
  logic [31:0]               out_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [OUT_WIDTH-1:0] exp_q[$];

  // Word A lanes {0x18,0xF8,0x80,0x7F}; word B lanes {0x04,0x03,0x02,0x01};
  // word C lanes {0x80,0x01,0xFF,0x00}.
  localparam logic [31:0] WORD_A = 32'h7F80F818;
  localparam logic [31:0] WORD_B = 32'h01020304;
  localparam logic [31:0] WORD_C = 32'h00FF0180;
  logic [15:0] exp_a[4] = '{16'h0180, 16'hFF80, 16'hF800, 16'h07F0};
  logic [15:0] exp_b[4] = '{16'h0040, 16'h0030, 16'h0020, 16'h0010};
  logic [15:0] exp_c[4] = '{16'hF800, 16'h0010, 16'hFFF0, 16'h0000};

  dequant_unpacker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lane (out_lane),
    .out_last (out_last),
    .dbg_state(dbg_state)
`ifdef DEQUANT_COUNT_EN
    ,
    .out_count(out_count)
`endif
  );

  // ---- clock / reset ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_lane !== 2'd0 ||
        out_last !== 1'b0 || in_ready !== 1'b1 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h lane=%0d last=%b in_ready=%b state=%0d, need 0/0000/0/0/1/IDLE",
               out_valid, out_data, out_lane, out_last, in_ready, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'h00000018; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready: got %b need 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0180 || out_lane !== 2'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL single_lane0: valid=%b data=%h lane=%0d last=%b, need 1/0180/0/0",
               out_valid, out_data, out_lane, out_last);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_negative();
    in_valid = 1'b1; in_data = WORD_A; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_a[i] || out_lane !== LW'(i) ||
          out_last !== (i == 3)) begin
        errors++;
        $display("FAIL negative_lane%0d: valid=%b data=%h lane=%0d last=%b, need 1/%h/%0d/%b",
                 i, out_valid, out_data, out_lane, out_last, exp_a[i], i, (i == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL negative_end: out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    in_valid = 1'b1; in_data = WORD_A; out_ready = 1'b1;
    @(negedge clk);
    in_data = WORD_B;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) in_valid = 1'b0;
      #1;
      e = (i < 4) ? exp_a[i] : exp_b[i-4];
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || out_lane !== LW'(i % 4) ||
          out_last !== ((i % 4) == 3) || in_ready !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL b2b_out%0d: valid=%b data=%h lane=%0d last=%b in_ready=%b, need 1/%h/%0d/%b/%b",
                 i, out_valid, out_data, out_lane, out_last, in_ready, e, i % 4,
                 ((i % 4) == 3), ((i % 4) == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = WORD_A; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    // A competing word offered during the stall must be ignored.
    in_valid = 1'b1; in_data = WORD_B;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hF800 || out_lane !== 2'd2 ||
          out_last !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: valid=%b data=%h lane=%0d last=%b in_ready=%b, need 1/f800/2/0/0",
                 k, out_valid, out_data, out_lane, out_last, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h07F0 || out_lane !== 2'd3 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: valid=%b data=%h lane=%0d last=%b, need 1/07f0/3/1",
               out_valid, out_data, out_lane, out_last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_end: out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; in_data = WORD_A; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_lane !== 2'd1 || out_data !== 16'hFF80) begin
      errors++; $display("FAIL midrst_pre: lane=%0d data=%h need 1/ff80", out_lane, out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_lane !== 2'd0 ||
        out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in: valid=%b data=%h lane=%0d last=%b in_ready=%b, need 0/0000/0/0/1",
               out_valid, out_data, out_lane, out_last, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release: valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = WORD_B;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0040 || out_lane !== 2'd0) begin
      errors++;
      $display("FAIL midrst_next: valid=%b data=%h lane=%0d need 1/0040/0", out_valid, out_data, out_lane);
    end
    repeat (4) @(negedge clk);
  endtask

`ifdef DEQUANT_COUNT_EN
  task automatic test_count();
    int sent = 0;
    int seen = 0;
    int cyc  = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [15:0] e;
    logic [31:0] words[3];
    words[0] = WORD_A; words[1] = WORD_B; words[2] = WORD_C;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_count !== 32'd0) begin
      errors++; $display("FAIL count_reset0: got %0d need 0", out_count);
    end
    while ((seen < 12) && (cyc < 300)) begin
      checks++;
      if (out_count !== exp_cnt) begin
        errors++; $display("FAIL count_track: got %0d need %0d", out_count, exp_cnt);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < 3);
      in_data   = (sent < 3) ? words[sent] : '0;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++; $display("FAIL count_data: got %h need %h", out_data, e);
        end
        seen++;
        exp_cnt++;
      end
      if (in_valid && in_ready) begin
        for (int l = 0; l < 4; l++) begin
          case (sent)
            0: exp_q.push_back(exp_a[l]);
            1: exp_q.push_back(exp_b[l]);
            default: exp_q.push_back(exp_c[l]);
          endcase
        end
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (seen != 12) begin
      errors++; $display("FAIL count_timeout: outputs seen %0d need 12", seen);
    end
    checks++;
    if (out_count !== 32'd12) begin
      errors++; $display("FAIL count_total: got %0d need 12", out_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_count !== 32'd0) begin
      errors++; $display("FAIL count_after_reset: got %0d need 0", out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
`ifdef DEQUANT_COUNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
